// File: rtl/level_peak_hold_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | level_peak_hold_if : min/max pair in, level/peak result out           |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface level_peak_hold_if #(
  parameter int WIDTH = 16
);
  localparam int SEG_W = $clog2(WIDTH);

  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_min_value;
  logic [WIDTH-1:0] i_max_value;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-2:0] o_level;
  logic [WIDTH-2:0] o_peak;
  logic [SEG_W-1:0] o_segment;
  logic [SEG_W-1:0] o_peak_segment;

  modport master (
    output i_valid, i_min_value, i_max_value, o_ready,
    input  i_ready, o_valid, o_level, o_peak, o_segment, o_peak_segment
  );

  modport slave (
    input  i_valid, i_min_value, i_max_value, o_ready,
    output i_ready, o_valid, o_level, o_peak, o_segment, o_peak_segment
  );
endinterface
`default_nettype wire

// File: rtl/level_peak_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | level_peak_hold : peak magnitude, decaying bar level and held peak    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module level_peak_hold #(
  parameter int WIDTH         = 16,
  parameter int HOLD_SECTIONS = 32,
  parameter int DECAY_STEP    = 256
) (
  input wire logic         clk,
  input wire logic         reset,
  level_peak_hold_if.slave bus
);
  localparam int SEG_W  = $clog2(WIDTH);
  localparam int HOLD_W = (HOLD_SECTIONS > 0) ? $clog2(HOLD_SECTIONS + 1) : 1;
  localparam logic [WIDTH-1:0]  MID     = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0]  MAG_MAX = MID - WIDTH'(1);
  localparam logic [WIDTH-2:0]  DECAY   = (WIDTH-1)'(DECAY_STEP);
  localparam logic [HOLD_W-1:0] HOLD    = HOLD_W'(HOLD_SECTIONS);

  typedef enum logic [1:0] {IDLE, CALC, UPDATE, OUT} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]  min_value, max_value;
  logic [WIDTH-2:0]  mag, level, peak;
  logic [HOLD_W-1:0] hold;

  logic [WIDTH-1:0]  pos, neg, mag_raw;
  logic [WIDTH-2:0]  level_dec, peak_dec, level_new, peak_new, peak_cand;
  logic [HOLD_W-1:0] hold_new;

  // Index of the highest set bit plus one; zero input maps to segment 0.
  function automatic logic [SEG_W-1:0] seg_of(input logic [WIDTH-2:0] x);
    seg_of = '0;
    for (int i = 0; i < WIDTH - 1; i++)
      if (x[i]) seg_of = SEG_W'(i + 1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.i_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.i_ready = 1'b1;
        if (bus.i_valid) state_next = CALC;
      end
      CALC:    state_next = UPDATE;
      UPDATE:  state_next = OUT;
      OUT:     if (bus.o_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pos     = (max_value > MID) ? max_value - MID : '0;
    neg     = (min_value < MID) ? MID - min_value : '0;
    mag_raw = (pos > neg) ? pos : neg;
    if (mag_raw > MAG_MAX) mag_raw = MAG_MAX;
  end

  always_comb begin
    level_dec = (level >= DECAY) ? level - DECAY : '0;
    peak_dec  = (peak  >= DECAY) ? peak  - DECAY : '0;
    if (mag >= level)          level_new = mag;
    else if (mag > level_dec)  level_new = mag;
    else                       level_new = level_dec;

    hold_new  = hold;
    peak_cand = peak;
    if (mag >= peak) begin
      peak_cand = mag;
      hold_new  = HOLD;
    end else if (hold != '0) begin
      hold_new  = hold - HOLD_W'(1);
    end else begin
      peak_cand = (peak_dec > level_new) ? peak_dec : level_new;
    end
    peak_new = (peak_cand > level_new) ? peak_cand : level_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_value          <= '0;
      max_value          <= '0;
      mag                <= '0;
      level              <= '0;
      peak               <= '0;
      hold               <= '0;
      bus.o_valid        <= 1'b0;
      bus.o_level        <= '0;
      bus.o_peak         <= '0;
      bus.o_segment      <= '0;
      bus.o_peak_segment <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          min_value <= bus.i_min_value;
          max_value <= bus.i_max_value;
        end
        CALC: mag <= mag_raw[WIDTH-2:0];
        UPDATE: begin
          level              <= level_new;
          peak               <= peak_new;
          hold               <= hold_new;
          bus.o_level        <= level_new;
          bus.o_peak         <= peak_new;
          bus.o_segment      <= seg_of(level_new);
          bus.o_peak_segment <= seg_of(peak_new);
          bus.o_valid        <= 1'b1;
        end
        OUT: if (bus.o_ready) bus.o_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_level_peak_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_level_peak_hold : directed vector bench for level_peak_hold        |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_level_peak_hold;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  level_peak_hold_if #(.WIDTH(16)) bus ();

  level_peak_hold #(.WIDTH(16), .HOLD_SECTIONS(4), .DECAY_STEP(256)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [14:0] level;
    logic [14:0] peak;
    logic [3:0]  seg;
    logic [3:0]  pseg;
  } vec_t;

  vec_t vecs [13];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, " level"}, 32'(bus.o_level), 32'(v.level));
    check({tag, " peak"}, 32'(bus.o_peak), 32'(v.peak));
    check({tag, " segment"}, 32'(bus.o_segment), 32'(v.seg));
    check({tag, " peak_segment"}, 32'(bus.o_peak_segment), 32'(v.pseg));
  endtask

  // Accept a pair and confirm o_valid rises exactly after the third edge.
  task automatic accept(input logic [15:0] mn, input logic [15:0] mx);
    @(negedge clk);
    check("i_ready idle", 32'(bus.i_ready), 32'd1);
    bus.i_valid     = 1'b1;
    bus.i_min_value = mn;
    bus.i_max_value = mx;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("o_valid after E0", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    check("o_valid after E1", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    check("o_valid after E2", 32'(bus.o_valid), 32'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
    check("o_valid after handshake", 32'(bus.o_valid), 32'd0);
    check("i_ready after handshake", 32'(bus.i_ready), 32'd1);
  endtask

  vec_t a, b;

  initial begin
    vecs[0]  = '{16'h8000, 16'h8000, 15'h0000, 15'h0000, 4'd0,  4'd0};
    vecs[1]  = '{16'h8000, 16'hC000, 15'h4000, 15'h4000, 4'd15, 4'd15};
    vecs[2]  = '{16'h8000, 16'h8000, 15'h3F00, 15'h4000, 4'd14, 4'd15};
    vecs[3]  = '{16'h8000, 16'h8000, 15'h3E00, 15'h4000, 4'd14, 4'd15};
    vecs[4]  = '{16'h8000, 16'h8000, 15'h3D00, 15'h4000, 4'd14, 4'd15};
    vecs[5]  = '{16'h8000, 16'h8000, 15'h3C00, 15'h4000, 4'd14, 4'd15};
    vecs[6]  = '{16'h8000, 16'h8000, 15'h3B00, 15'h3F00, 4'd14, 4'd14};
    vecs[7]  = '{16'h0000, 16'h8000, 15'h7FFF, 15'h7FFF, 4'd15, 4'd15};
    vecs[8]  = '{16'h7000, 16'h9000, 15'h7EFF, 15'h7FFF, 4'd15, 4'd15};
    vecs[9]  = '{16'h7FFF, 16'h8000, 15'h7DFF, 15'h7FFF, 4'd15, 4'd15};
    vecs[10] = '{16'h8000, 16'hFFFF, 15'h7FFF, 15'h7FFF, 4'd15, 4'd15};
    vecs[11] = '{16'h8000, 16'h8100, 15'h7EFF, 15'h7FFF, 4'd15, 4'd15};
    vecs[12] = '{16'h8000, 16'hFE00, 15'h7E00, 15'h7FFF, 4'd15, 4'd15};

    bus.i_valid     = 1'b0;
    bus.i_min_value = '0;
    bus.i_max_value = '0;
    bus.o_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset o_valid", 32'(bus.o_valid), 32'd0);
    check("reset i_ready", 32'(bus.i_ready), 32'd1);
    check_out("reset", '{16'h0, 16'h0, 15'h0, 15'h0, 4'd0, 4'd0});
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      accept(vecs[i].mn, vecs[i].mx);
      check_out($sformatf("vec%0d", i), vecs[i]);
      release_out();
    end

    // Asynchronous reset while holding a result in OUT.
    accept(16'h8000, 16'hC000);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async reset o_valid", 32'(bus.o_valid), 32'd0);
    check("async reset i_ready", 32'(bus.i_ready), 32'd1);
    check_out("async reset", '{16'h0, 16'h0, 15'h0, 15'h0, 4'd0, 4'd0});
    @(negedge clk);
    reset = 1'b0;

    // Cleared state: smallest non-zero magnitude, then decay floors at zero.
    accept(16'h8000, 16'h8001);
    check_out("mag one", '{16'h0, 16'h0, 15'h0001, 15'h0001, 4'd1, 4'd1});
    release_out();
    accept(16'h8000, 16'h8000);
    check_out("decay floor", '{16'h0, 16'h0, 15'h0000, 15'h0001, 4'd0, 4'd1});
    release_out();

    // Downstream stall with a new pair waiting upstream.
    a = '{16'h8000, 16'hA000, 15'h2000, 15'h2000, 4'd14, 4'd14};
    b = '{16'h7000, 16'h8000, 15'h1F00, 15'h2000, 4'd13, 4'd14};
    accept(a.mn, a.mx);
    check_out("stall first", a);
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_min_value = b.mn;
    bus.i_max_value = b.mx;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall o_valid", 32'(bus.o_valid), 32'd1);
      check("stall i_ready", 32'(bus.i_ready), 32'd0);
      check("stall level", 32'(bus.o_level), 32'(a.level));
      check("stall peak", 32'(bus.o_peak), 32'(a.peak));
    end
    release_out();
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("queued accept i_ready", 32'(bus.i_ready), 32'd0);
    @(posedge clk); #1;
    check("queued o_valid E1", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    check("queued o_valid E2", 32'(bus.o_valid), 32'd1);
    check_out("stall second", b);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
